deparse_act_sequencer: RTL

Sequences a per-packet list of deparser actions onto a bank of `C_NUM_LANES` parallel `sub_deparser` lanes.
- Accepts one PHV plus its action list through a valid/ready handshake and holds the PHV in a register.
- Issues up to `C_NUM_LANES` actions per cycle until the list ends, waits out the lanes' one-cycle latency, then signals completion.
- Sits between the pipeline's last stage and the lane bank. Downstream uses the round tag to align the lanes' `val_out` results.

---
 rtl/deparse_pkg.sv | 36 +++
 rtl/deparse_act_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/deparse_pkg.sv
// rtl/deparse_pkg.sv - shared constants and types for the deparser action sequencer
//
// Purpose: PHV and action geometry, the action field layout, the action type
// codes and the sequencer state encoding.
// Ports: none (package).
package deparse_pkg;

  // PHV: twelve 512-bit container segments plus 256 bits of metadata.
  localparam int C_PHV_NUM_SEGS  = 6 + 4 + 2;
  localparam int C_PHV_SEG_BITS  = 64 * 8;
  localparam int C_PHV_META_BITS = 256;
  localparam int C_PKT_VEC_WIDTH = C_PHV_NUM_SEGS * C_PHV_SEG_BITS + C_PHV_META_BITS;

  // One action: {type[8:7], idx[6:1], valid[0]}.
  localparam int C_PARSE_ACT_LEN = 9;
  localparam int C_ACT_VALID_BIT = 0;
  localparam int C_ACT_IDX_LSB   = 1;
  localparam int C_ACT_IDX_MSB   = 6;
  localparam int C_ACT_TYPE_LSB  = 7;
  localparam int C_ACT_TYPE_MSB  = 8;

  localparam logic [1:0] C_ACT_TYPE_2B = 2'b01;
  localparam logic [1:0] C_ACT_TYPE_4B = 2'b10;
  localparam logic [1:0] C_ACT_TYPE_8B = 2'b11;

  localparam int C_NUM_ACTS  = 10;
  localparam int C_NUM_LANES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/deparse_act_sequencer.sv
// rtl/deparse_act_sequencer.sv - issues a packet's deparser actions onto parallel lanes
//
// Purpose: accepts one PHV and its action list, then drives C_NUM_LANES actions
// per cycle (round r, lane l -> slot r*L+l) until the first slot with a clear
// valid bit, waits one cycle for the lanes' registered latency and reports the
// number of actions issued.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   phv_in_valid/phv_in_ready packet acceptance handshake
//   phv_in, act_list_in       PHV and action list (slot k at [k*LEN +: LEN])
//   sub_act_valid, sub_act    per-lane action (lane l at [l*LEN +: LEN])
//   sub_phv                   latched PHV shared by all lanes
//   res_valid, res_round      lane results valid this cycle, for round res_round
//   done_valid/done_ready     completion handshake
//   done_num_acts             actions issued for the packet
module deparse_act_sequencer #(
  parameter int C_PKT_VEC_WIDTH = deparse_pkg::C_PKT_VEC_WIDTH,
  parameter int C_PARSE_ACT_LEN = deparse_pkg::C_PARSE_ACT_LEN,
  parameter int C_NUM_ACTS      = deparse_pkg::C_NUM_ACTS,
  parameter int C_NUM_LANES     = deparse_pkg::C_NUM_LANES,
  localparam int C_NUM_ROUNDS   = (C_NUM_ACTS + C_NUM_LANES - 1) / C_NUM_LANES,
  localparam int C_ROUND_W      = (C_NUM_ROUNDS > 1) ? $clog2(C_NUM_ROUNDS) : 1,
  localparam int C_CNT_W        = $clog2(C_NUM_ACTS + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  phv_in_valid,
  output logic                                  phv_in_ready,
  input  logic [C_PKT_VEC_WIDTH-1:0]            phv_in,
  input  logic [C_NUM_ACTS*C_PARSE_ACT_LEN-1:0] act_list_in,
  output logic [C_NUM_LANES-1:0]                sub_act_valid,
  output logic [C_NUM_LANES*C_PARSE_ACT_LEN-1:0] sub_act,
  output logic [C_PKT_VEC_WIDTH-1:0]            sub_phv,
  output logic                                  res_valid,
  output logic [C_ROUND_W-1:0]                  res_round,
  output logic                                  done_valid,
  input  logic                                  done_ready,
  output logic [C_CNT_W-1:0]                    done_num_acts
);

  import deparse_pkg::*;

  localparam int LEN = C_PARSE_ACT_LEN;
  localparam int L   = C_NUM_LANES;

  state_e                       state_q, state_d;
  logic                         ready_q, ready_d;
  logic [C_PKT_VEC_WIDTH-1:0]   phv_q, phv_d;
  logic [C_NUM_ACTS*LEN-1:0]    acts_q, acts_d;
  logic [C_CNT_W-1:0]           term_q, term_d, term_in;
  logic [C_ROUND_W-1:0]         round_q, round_d;
  logic                         res_valid_q, res_valid_d;
  logic [C_ROUND_W-1:0]         res_round_q, res_round_d;
  logic [C_CNT_W-1:0]           done_num_q, done_num_d;

  logic [C_NUM_LANES-1:0]       lane_valid;
  logic [C_NUM_LANES*LEN-1:0]   lane_act;
  logic                         last_round;
  int                           lane_slot;

  // Terminator: lowest slot whose valid bit is clear, C_NUM_ACTS if none.
  // Evaluated on the incoming list and registered at acceptance.
  always_comb begin
    term_in = C_CNT_W'(C_NUM_ACTS);
    for (int k = C_NUM_ACTS - 1; k >= 0; k--) begin
      if (!act_list_in[k*LEN + C_ACT_VALID_BIT]) begin
        term_in = C_CNT_W'(k);
      end
    end
  end

  // Lane drive for the current round. Slots at or above the terminator are
  // suppressed even when their own valid bit is set.
  always_comb begin
    lane_valid = '0;
    lane_act   = '0;
    lane_slot  = 0;
    for (int l = 0; l < L; l++) begin
      lane_slot = int'(round_q) * L + l;
      if (state_q == ST_ISSUE && lane_slot < int'(term_q)) begin
        lane_valid[l] = 1'b1;
        for (int k = 0; k < C_NUM_ACTS; k++) begin
          if (k == lane_slot) begin
            lane_act[l*LEN +: LEN] = acts_q[k*LEN +: LEN];
          end
        end
      end
    end
  end

  // Last round is the one containing the terminator, or the final round.
  // With the terminator at slot 0 this is round 0, which issues nothing.
  assign last_round = ((int'(round_q) + 1) * L > int'(term_q)) ||
                      (int'(round_q) == C_NUM_ROUNDS - 1);

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    phv_d       = phv_q;
    acts_d      = acts_q;
    term_d      = term_q;
    round_d     = round_q;
    res_valid_d = 1'b0;
    res_round_d = res_round_q;
    done_num_d  = done_num_q;

    case (state_q)
      ST_IDLE: begin
        if (phv_in_valid && ready_q) begin
          phv_d   = phv_in;
          acts_d  = act_list_in;
          term_d  = term_in;
          round_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The lanes register their result, so the tag trails the issue by one.
        if (|lane_valid) begin
          res_valid_d = 1'b1;
          res_round_d = round_q;
        end
        if (last_round) begin
          done_num_d = term_q;
          state_d    = ST_DRAIN;
        end else begin
          round_d = round_q + C_ROUND_W'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered ready stays low through reset and rises one cycle after it.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      phv_q       <= '0;
      acts_q      <= '0;
      term_q      <= '0;
      round_q     <= '0;
      res_valid_q <= 1'b0;
      res_round_q <= '0;
      done_num_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      phv_q       <= phv_d;
      acts_q      <= acts_d;
      term_q      <= term_d;
      round_q     <= round_d;
      res_valid_q <= res_valid_d;
      res_round_q <= res_round_d;
      done_num_q  <= done_num_d;
    end
  end

  assign phv_in_ready  = ready_q;
  assign sub_act_valid = lane_valid;
  assign sub_act       = lane_act;
  assign sub_phv       = phv_q;
  assign res_valid     = res_valid_q;
  assign res_round     = res_round_q;
  assign done_valid    = (state_q == ST_DONE);
  assign done_num_acts = done_num_q;

endmodule
